// File: rtl/sm3_pad_stream_if.sv
// Host-side message stream and core-side padded stream for the SM3 padder.
interface sm3_pad_stream_if #(
    parameter int unsigned DW = 64
);
    logic              in_vld;
    logic              in_rdy;
    logic [DW-1:0]     in_data;
    logic [DW/8-1:0]   in_keep;
    logic              in_last;
    logic              out_vld;
    logic              out_rdy;
    logic [DW-1:0]     out_data;
    logic              out_blk_last;
    logic              out_last;

    modport master (
        output in_vld, in_data, in_keep, in_last, out_rdy,
        input  in_rdy, out_vld, out_data, out_blk_last, out_last
    );

    modport slave (
        input  in_vld, in_data, in_keep, in_last, out_rdy,
        output in_rdy, out_vld, out_data, out_blk_last, out_last
    );
endinterface

// File: rtl/sm3_pad_stream.sv
// SM3 message padder: passes message beats through, appends 0x80, zero fill and
// the 64-bit big-endian bit length, emitting whole 512-bit blocks.
module sm3_pad_stream #(
    parameter int unsigned DW  = 64,
    parameter int unsigned KW  = DW / 8,
    parameter int unsigned BPB = 512 / DW
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clr,
    sm3_pad_stream_if.slave bus
);
    localparam int unsigned PW = $clog2(BPB);
    localparam int unsigned CW = $clog2(KW + 1);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] beat_pos_q, beat_pos_d, nxt_pos;
    logic [60:0]   byte_cnt_q, byte_cnt_d, cnt_new;
    logic          pend80_q, pend80_d;     // 0x80 still owed (last beat was full)
    logic          pad_done_q, pad_done_d; // 0x80 already emitted
    logic          len_ok_q, len_ok_d;     // current block carries the length
    logic          out_vld_q, out_vld_d;
    logic          out_blk_last_q, out_blk_last_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] beat;
    logic [CW-1:0] keep_cnt, k80;
    logic [63:0]   bit_len;
    logic          can_load, xfer, in_rdy, acc, tail, ins80, final_beat, load, go_idle;

    // Number of valid bytes on the last beat.
    always_comb begin
        keep_cnt = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            keep_cnt = keep_cnt + CW'(bus.in_keep[i]);
        end
    end

    assign can_load = !out_vld_q || bus.out_rdy;
    assign xfer     = out_vld_q && bus.out_rdy;
    // Block position of the beat that would be loaded this cycle.
    assign nxt_pos  = !xfer ? beat_pos_q :
                      (beat_pos_q == PW'(BPB - 1)) ? '0 : beat_pos_q + 1'b1;
    assign in_rdy   = (state_q != StTail) && can_load && !clr && rst_n;
    assign acc      = bus.in_vld && in_rdy;
    assign tail     = (state_q == StTail);
    assign cnt_new  = byte_cnt_q + (!acc ? 61'd0 : bus.in_last ? 61'(keep_cnt) : 61'(KW));
    assign bit_len  = {cnt_new, 3'b000};

    // Build the candidate output beat byte by byte from its position in the block.
    always_comb begin
        ins80 = tail ? pend80_q : (bus.in_last && (32'(keep_cnt) < KW));
        k80   = tail ? '0 : keep_cnt;
        // Length lands in this block once 0x80 sits at byte 55 or earlier, or after
        // the overflow block has started.
        final_beat = len_ok_q || (pad_done_q && (nxt_pos == '0)) ||
                     (ins80 && ((32'(nxt_pos) * KW + 32'(k80)) <= 55));
        beat = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            logic [7:0]  byte_v;
            int unsigned b;
            b      = 32'(nxt_pos) * KW + i;
            byte_v = tail ? 8'h00 : bus.in_data[DW-1-8*i -: 8];
            if (!tail && bus.in_last && (i >= 32'(keep_cnt))) byte_v = 8'h00;
            if (ins80 && (i == 32'(k80))) byte_v = 8'h80;
            if (final_beat && (b >= 56)) byte_v = 8'(bit_len >> (8 * (63 - b)));
            beat[DW-1-8*i -: 8] = byte_v;
        end
    end

    // Next-state: FSM, output register loading and counter maintenance.
    always_comb begin
        state_d        = state_q;
        pend80_d       = pend80_q;
        pad_done_d     = pad_done_q;
        len_ok_d       = len_ok_q;
        out_vld_d      = out_vld_q;
        out_data_d     = out_data_q;
        out_blk_last_d = out_blk_last_q;
        out_last_d     = out_last_q;
        beat_pos_d     = nxt_pos;
        byte_cnt_d     = cnt_new;
        load           = 1'b0;
        go_idle        = 1'b0;
        case (state_q)
            StIdle, StData: begin
                if (acc) begin
                    load     = 1'b1;
                    state_d  = bus.in_last ? StTail : StData;
                    pend80_d = bus.in_last && (32'(keep_cnt) == KW);
                end
            end
            StTail: begin
                if (out_vld_q && out_last_q) begin
                    if (bus.out_rdy) begin
                        state_d = StIdle;
                        go_idle = 1'b1;
                    end
                end else if (can_load) begin
                    load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            out_vld_d      = 1'b1;
            out_data_d     = beat;
            out_blk_last_d = (nxt_pos == PW'(BPB - 1));
            out_last_d     = final_beat && (nxt_pos == PW'(BPB - 1));
            len_ok_d       = final_beat;
            if (ins80) begin
                pad_done_d = 1'b1;
                pend80_d   = 1'b0;
            end
        end else if (xfer) begin
            out_vld_d      = 1'b0;
            out_blk_last_d = 1'b0;
            out_last_d     = 1'b0;
        end
        if (go_idle) begin
            byte_cnt_d = '0;
            beat_pos_d = '0;
            pend80_d   = 1'b0;
            pad_done_d = 1'b0;
            len_ok_d   = 1'b0;
        end
    end

    // State register; clr behaves like reset but synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            beat_pos_q     <= '0;
            byte_cnt_q     <= '0;
            pend80_q       <= 1'b0;
            pad_done_q     <= 1'b0;
            len_ok_q       <= 1'b0;
            out_vld_q      <= 1'b0;
            out_data_q     <= '0;
            out_blk_last_q <= 1'b0;
            out_last_q     <= 1'b0;
        end else if (clr) begin
            state_q        <= StIdle;
            beat_pos_q     <= '0;
            byte_cnt_q     <= '0;
            pend80_q       <= 1'b0;
            pad_done_q     <= 1'b0;
            len_ok_q       <= 1'b0;
            out_vld_q      <= 1'b0;
            out_data_q     <= '0;
            out_blk_last_q <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_pos_q     <= beat_pos_d;
            byte_cnt_q     <= byte_cnt_d;
            pend80_q       <= pend80_d;
            pad_done_q     <= pad_done_d;
            len_ok_q       <= len_ok_d;
            out_vld_q      <= out_vld_d;
            out_data_q     <= out_data_d;
            out_blk_last_q <= out_blk_last_d;
            out_last_q     <= out_last_d;
        end
    end

    assign bus.in_rdy       = in_rdy;
    assign bus.out_vld      = out_vld_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_blk_last = out_blk_last_q;
    assign bus.out_last     = out_last_q;
endmodule

// File: tb/tb_sm3_pad_stream.sv
// Scoreboard bench for sm3_pad_stream at DW = 32, 64 and 128.
module tb_sm3_pad_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic rdy_bit = 1'b1;
    int   rdy_mode = 0;
    bit   mon_en = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sm3_pad_stream_if #(.DW(32))  bus32 ();
    sm3_pad_stream_if #(.DW(64))  bus64 ();
    sm3_pad_stream_if #(.DW(128)) bus128 ();

    sm3_pad_stream #(.DW(32))  dut32  (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus32));
    sm3_pad_stream #(.DW(64))  dut64  (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus64));
    sm3_pad_stream #(.DW(128)) dut128 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus128));

    assign bus32.out_rdy  = rdy_bit;
    assign bus64.out_rdy  = rdy_bit;
    assign bus128.out_rdy = rdy_bit;

    // Downstream ready: always, random 50%, or stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rdy_bit = 1'b1;
            1:       rdy_bit = 1'($urandom_range(0, 1));
            default: rdy_bit = 1'b0;
        endcase
    end

    typedef struct {
        logic [127:0] data;
        logic         blk;
        logic         last;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t q128[$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic int kw_of(int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
    endfunction

    function automatic int qsize(int sel);
        case (sel)
            0:       return q32.size();
            1:       return q64.size();
            default: return q128.size();
        endcase
    endfunction

    function automatic logic get_vld(int sel);
        case (sel)
            0:       return bus32.out_vld;
            1:       return bus64.out_vld;
            default: return bus128.out_vld;
        endcase
    endfunction

    function automatic logic get_in_rdy(int sel);
        case (sel)
            0:       return bus32.in_rdy;
            1:       return bus64.in_rdy;
            default: return bus128.in_rdy;
        endcase
    endfunction

    task automatic push_exp(int sel, logic [127:0] d, logic blk, logic last);
        exp_t e;
        e.data = d;
        e.blk  = blk;
        e.last = last;
        case (sel)
            0:       q32.push_back(e);
            1:       q64.push_back(e);
            default: q128.push_back(e);
        endcase
    endtask

    task automatic push_zeros(int sel, int n);
        for (int i = 0; i < n; i++) push_exp(sel, 128'h0, 1'b0, 1'b0);
    endtask

    // Monitor state per DUT.
    logic         prev_stall[3];
    logic [127:0] prev_data[3];
    logic [1:0]   prev_flags[3];

    task automatic mon_step(int sel, logic vld, logic rdy, logic [127:0] d, logic blk, logic last);
        exp_t e;
        bit   have;
        if (prev_stall[sel]) begin
            chk($sformatf("hold_vld_dw%0d", kw_of(sel) * 8), 128'(vld), 128'h1);
            chk($sformatf("hold_data_dw%0d", kw_of(sel) * 8), d, prev_data[sel]);
            chk($sformatf("hold_flags_dw%0d", kw_of(sel) * 8), 128'({blk, last}),
                128'(prev_flags[sel]));
        end
        if (vld && rdy) begin
            have = 1'b0;
            case (sel)
                0:       if (q32.size() > 0)  begin e = q32.pop_front();  have = 1'b1; end
                1:       if (q64.size() > 0)  begin e = q64.pop_front();  have = 1'b1; end
                default: if (q128.size() > 0) begin e = q128.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_checks++;
                $display("FAIL unexpected_beat_dw%0d: got %0h required no beat", kw_of(sel) * 8, d);
            end else begin
                chk($sformatf("beat_data_dw%0d", kw_of(sel) * 8), d, e.data);
                chk($sformatf("beat_flags_dw%0d", kw_of(sel) * 8), 128'({blk, last}),
                    128'({e.blk, e.last}));
            end
        end
        prev_stall[sel] = vld && !rdy;
        prev_data[sel]  = d;
        prev_flags[sel] = {blk, last};
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, bus32.out_vld, bus32.out_rdy, 128'(bus32.out_data),
                     bus32.out_blk_last, bus32.out_last);
            mon_step(1, bus64.out_vld, bus64.out_rdy, 128'(bus64.out_data),
                     bus64.out_blk_last, bus64.out_last);
            mon_step(2, bus128.out_vld, bus128.out_rdy, bus128.out_data,
                     bus128.out_blk_last, bus128.out_last);
        end else begin
            for (int s = 0; s < 3; s++) prev_stall[s] = 1'b0;
        end
    end

    // Present one input beat and hold it until accepted.
    task automatic send_beat(int sel, logic [127:0] d, int k, logic last);
        logic [15:0] km;
        bit          acc;
        int          n;
        km = 16'(((32'd1 << k) - 1) << (kw_of(sel) - k));
        @(negedge clk);
        case (sel)
            0: begin
                bus32.in_vld = 1'b1; bus32.in_data = d[31:0];
                bus32.in_keep = km[3:0]; bus32.in_last = last;
            end
            1: begin
                bus64.in_vld = 1'b1; bus64.in_data = d[63:0];
                bus64.in_keep = km[7:0]; bus64.in_last = last;
            end
            default: begin
                bus128.in_vld = 1'b1; bus128.in_data = d;
                bus128.in_keep = km; bus128.in_last = last;
            end
        endcase
        acc = 1'b0;
        for (n = 0; n < 500; n++) begin
            #1;
            acc = get_in_rdy(sel);
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL in_accept_timeout_dw%0d: got no acceptance required acceptance",
                     kw_of(sel) * 8);
        end
    endtask

    task automatic end_msg();
        @(negedge clk);
        bus32.in_vld = 1'b0;  bus32.in_last = 1'b0;
        bus64.in_vld = 1'b0;  bus64.in_last = 1'b0;
        bus128.in_vld = 1'b0; bus128.in_last = 1'b0;
    endtask

    // First k bytes = b, rest 0xEE (must be masked off by the padder).
    function automatic logic [127:0] fill_beat(int sel, int k, logic [7:0] b);
        logic [127:0] r;
        int kw;
        kw = kw_of(sel);
        r = '0;
        for (int j = 0; j < kw; j++) r[8*(kw-1-j) +: 8] = (j < k) ? b : 8'hEE;
        return r;
    endfunction

    task automatic send_fill(int sel, int nbytes, logic [7:0] b);
        int kw, full, rem;
        kw = kw_of(sel);
        full = nbytes / kw;
        rem = nbytes % kw;
        if (nbytes > 0 && rem == 0) begin
            for (int i = 0; i < full; i++)
                send_beat(sel, fill_beat(sel, kw, b), kw, (i == full - 1));
        end else begin
            for (int i = 0; i < full; i++) send_beat(sel, fill_beat(sel, kw, b), kw, 1'b0);
            send_beat(sel, fill_beat(sel, rem, b), rem, 1'b1);
        end
        end_msg();
    endtask

    task automatic drain(int sel);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            if (qsize(sel) == 0 && !get_vld(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL drain_timeout_dw%0d: got %0d beats pending required 0",
                     kw_of(sel) * 8, qsize(sel));
        end
    endtask

    task automatic push_abc32();
        push_exp(0, 128'h61626380, 1'b0, 1'b0);
        push_zeros(0, 14);
        push_exp(0, 128'h18, 1'b1, 1'b1);
    endtask

    task automatic run_abc32();
        push_abc32();
        send_beat(0, 128'h616263EE, 3, 1'b1);
        end_msg();
        drain(0);
    endtask

    task automatic run_56_64();
        for (int i = 0; i < 7; i++) push_exp(1, 128'h0101010101010101, 1'b0, 1'b0);
        push_exp(1, 128'h8000000000000000, 1'b1, 1'b0);
        push_zeros(1, 7);
        push_exp(1, 128'h1C0, 1'b1, 1'b1);
        send_fill(1, 56, 8'h01);
        drain(1);
    endtask

    initial begin
        bus32.in_vld = 1'b0;  bus32.in_data = '0;  bus32.in_keep = '0;  bus32.in_last = 1'b0;
        bus64.in_vld = 1'b0;  bus64.in_data = '0;  bus64.in_keep = '0;  bus64.in_last = 1'b0;
        bus128.in_vld = 1'b0; bus128.in_data = '0; bus128.in_keep = '0; bus128.in_last = 1'b0;
        for (int s = 0; s < 3; s++) prev_stall[s] = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld32", 128'(bus32.out_vld), 128'h0);
        chk("rst_data32", 128'(bus32.out_data), 128'h0);
        chk("rst_flags32", 128'({bus32.out_blk_last, bus32.out_last}), 128'h0);
        chk("rst_in_rdy32", 128'(bus32.in_rdy), 128'h0);
        chk("rst_vld64", 128'(bus64.out_vld), 128'h0);
        chk("rst_data64", 128'(bus64.out_data), 128'h0);
        chk("rst_flags64", 128'({bus64.out_blk_last, bus64.out_last}), 128'h0);
        chk("rst_vld128", 128'(bus128.out_vld), 128'h0);
        chk("rst_data128", bus128.out_data, 128'h0);
        chk("rst_flags128", 128'({bus128.out_blk_last, bus128.out_last}), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_rdy64", 128'(bus64.in_rdy), 128'h1);

        // "abc", DW=32.
        run_abc32();

        // 55 bytes, DW=64: padding fits in one block.
        for (int i = 0; i < 6; i++) push_exp(1, 128'h0101010101010101, 1'b0, 1'b0);
        push_exp(1, 128'h0101010101010180, 1'b0, 1'b0);
        push_exp(1, 128'h1B8, 1'b1, 1'b1);
        send_fill(1, 55, 8'h01);
        drain(1);

        // 56 bytes, DW=64: extra block.
        run_56_64();

        // 64 bytes, DW=128.
        for (int i = 0; i < 4; i++)
            push_exp(2, {16{8'h01}}, (i == 3), 1'b0);
        push_exp(2, {8'h80, 120'h0}, 1'b0, 1'b0);
        push_zeros(2, 2);
        push_exp(2, 128'h200, 1'b1, 1'b1);
        send_fill(2, 64, 8'h01);
        drain(2);

        // Empty messages.
        push_exp(0, 128'h80000000, 1'b0, 1'b0);
        push_zeros(0, 14);
        push_exp(0, 128'h0, 1'b1, 1'b1);
        send_fill(0, 0, 8'h00);
        drain(0);
        push_exp(1, 128'h8000000000000000, 1'b0, 1'b0);
        push_zeros(1, 6);
        push_exp(1, 128'h0, 1'b1, 1'b1);
        send_fill(1, 0, 8'h00);
        drain(1);
        push_exp(2, {8'h80, 120'h0}, 1'b0, 1'b0);
        push_zeros(2, 2);
        push_exp(2, 128'h0, 1'b1, 1'b1);
        send_fill(2, 0, 8'h00);
        drain(2);

        // Random downstream back-pressure.
        rdy_mode = 1;
        run_abc32();
        run_56_64();
        rdy_mode = 0;
        @(posedge clk);

        // Soft clear mid-DATA, then a clean "abc".
        mon_en = 1'b0;
        send_beat(0, 128'h01020304, 4, 1'b0);
        send_beat(0, 128'h05060708, 4, 1'b0);
        @(negedge clk);
        bus32.in_vld = 1'b0;
        clr = 1'b1;
        #1;
        chk("clr_in_rdy", 128'(bus32.in_rdy), 128'h0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_out_vld", 128'(bus32.out_vld), 128'h0);
        q32.delete();
        mon_en = 1'b1;
        run_abc32();

        // Async reset mid-TAIL, then a clean "abc".
        mon_en = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        #2;
        push_abc32();
        send_beat(0, 128'h616263EE, 3, 1'b1);
        end_msg();
        repeat (4) @(negedge clk);
        #1;
        chk("tail_stall_vld", 128'(bus32.out_vld), 128'h1);
        chk("tail_stall_in_rdy", 128'(bus32.in_rdy), 128'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_tail_vld", 128'(bus32.out_vld), 128'h0);
        chk("rst_tail_data", 128'(bus32.out_data), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        q32.delete();
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        run_abc32();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sm3_pad_stream.md
Name: sm3_pad_stream

Overview:
- Parametrised SM3 message padder between the host message interface and the SM3 compression core.
- Accepts a byte-granular message stream of width DW with valid/ready back-pressure on both sides.
- Emits message || 0x80 || 0x00… || 64-bit big-endian bit length, in whole 512-bit blocks, with per-block and per-message last flags.

Parameters:
- DW, 64, data width in bits; legal values 32, 64, 128.
- KW, DW/8, byte-keep width (derived; do not override).
- BPB, 512/DW, beats per 512-bit block (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous soft clear; abandons the current message
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld && in_rdy
- in_data  in  DW  message bytes, big-endian: byte 0 in bits [DW-1:DW-8]
- in_keep  in  KW  valid bytes on the last beat; MSB-first contiguous; 0 allowed; ignored on non-last beats
- in_last  in  1  final beat of message
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream ready
- out_data  out  DW  padded stream beat
- out_blk_last  out  1  beat is the last beat of a 512-bit block
- out_last  out  1  beat is the final beat of the padded message (implies out_blk_last)

Behaviour:
- Reset (async) and clr (sync): state=IDLE, out_vld=0, out_data=0, out_blk_last=0, out_last=0, in_rdy=0 for that cycle, byte and beat counters cleared. clr wins over every other event in the same cycle; the partially emitted message is dropped.
- Output stage: single register. A beat is transferred when out_vld && out_rdy. While out_vld && !out_rdy, out_data and flags stay stable. Latency from input acceptance to out_vld is 1 cycle.
- in_rdy = (state==DATA || state==IDLE) && (!out_vld || out_rdy) && !clr.
- Counters:
  - byte_cnt: 61 bits; adds KW per accepted non-last beat and popcount(in_keep) on the last beat.
  - bit_len = {byte_cnt, 3'b0}; wraps modulo 2^64. Messages of 2^61 bytes or more are unsupported.
  - beat_pos: 0..BPB-1; increments on each output transfer and wraps at BPB. out_blk_last = (beat_pos == BPB-1).
- Output stream content: message bytes, then one 0x80 byte, then the minimum number of 0x00 bytes so that total bytes ≡ 56 (mod 64), then bit_len as 8 bytes MSB first.
  - r = byte_cnt mod 64. If r ≤ 55 the padding fits in one block; otherwise exactly one extra block is appended.
- Last input beat, k = popcount(in_keep):
  - k < KW: output in_data with byte k forced to 0x80 and bytes > k zeroed.
  - k == KW: output in_data unchanged, and 0x80 opens the next beat.
- FSM states:
  - IDLE: waits for the first beat; goes to DATA, or to TAIL when in_last is set.
  - DATA: passes beats through; an accepted in_last beat goes to TAIL.
  - TAIL: generates the remaining beats of the block from byte position, in this order: 0x80 if still pending, zeros, then the length.
    - DW=32: two length beats (high word, then low word).
    - DW=64: one length beat.
    - DW=128: the final beat is {upper 64 bits = pad/zero, lower 64 bits = bit_len}.
  - Out of TAIL: after the out_last transfer, return to IDLE and clear the counters.
- in_rdy is low throughout TAIL; the next message starts no earlier than the cycle after the out_last transfer.
- Simultaneous last-beat acceptance and output stall: the input is not accepted (in_rdy low), so no beat is lost.
- Only one message is in flight at a time.

Test Plan:
- DW=32, "abc": one beat 0x61626300, keep=1110, last -> 16 beats: 0x61626380, 14×0x00000000, 0x00000018. out_blk_last and out_last are set only on beat 16.
- DW=64, 55-byte message (0x01 repeated) -> 8 beats, one block; beat 7 = 0x0101010101010180; beat 8 = 0x00000000000001B8.
- DW=64, 56-byte message -> 16 beats, two blocks; beat 8 = 0x8000000000000000; beat 16 = 0x00000000000001C0. out_blk_last is set on beats 8 and 16; out_last only on beat 16.
- DW=128, 64-byte message -> 8 beats. Beat 5 = 0x80 followed by zeros. Beat 8 = {64'h0, 64'h200}.
- Empty message, any DW (in_last, keep=0) -> one block: first byte 0x80, all others 0, length 0.
- Random out_rdy (50%) on the "abc" and 56-byte cases -> identical output sequence; data and flags held stable while stalled.
- clr asserted mid-DATA -> out_vld=0 the next cycle; a following "abc" message produces exactly the clean "abc" result.
- rst_n asserted mid-TAIL -> same clean recovery as clr.
